// File: rtl/cpu_pkg.sv
// Shared fetch-path constants: next-PC select encodings, NOP encoding and default trap vectors.
package cpu_pkg;

  localparam int unsigned PCSRC_W = 3;
  localparam int unsigned INSTR_W = 32;

  localparam logic [PCSRC_W-1:0] PCSRC_SEQ   = 3'd0;
  localparam logic [PCSRC_W-1:0] PCSRC_BR    = 3'd1;
  localparam logic [PCSRC_W-1:0] PCSRC_J     = 3'd2;
  localparam logic [PCSRC_W-1:0] PCSRC_JR    = 3'd3;
  localparam logic [PCSRC_W-1:0] PCSRC_ILLOP = 3'd4;
  localparam logic [PCSRC_W-1:0] PCSRC_IRQ   = 3'd5;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

  // Vectors are 32-bit; wider datapaths zero-extend them.
  localparam logic [31:0] RESET_VEC_DEF = 32'h8000_0000;
  localparam logic [31:0] ILLOP_VEC_DEF = 32'h8000_0004;
  localparam logic [31:0] XADR_VEC_DEF  = 32'h8000_0008;

endpackage

// File: rtl/fetch_stage_pc_next_sel.sv
// pc_next_sel: priority next-PC mux with supervisor-bit masking.
// FETCH_IRQ_EN enables the level irq input (user mode only).
module pc_next_sel
  import cpu_pkg::*;
#(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] ILLOP_VEC = XLEN'(ILLOP_VEC_DEF),
  parameter logic [XLEN-1:0] XADR_VEC  = XLEN'(XADR_VEC_DEF)
) (
  input  logic [XLEN-1:0]    pc,
  input  logic [PCSRC_W-1:0] pcsrc,
  input  logic               branch_taken,
  input  logic [XLEN-1:0]    branch_target,
  input  logic [XLEN-1:0]    jr_target,
  input  logic               irq,
  input  logic [INSTR_W-1:0] id_instr,
  input  logic [XLEN-1:0]    id_pc4,
  output logic [XLEN-1:0]    next_pc,
  output logic               redirect,
  output logic               irq_take
);

  localparam int unsigned MSB = XLEN - 1;

  logic            irq_lvl;
  logic [XLEN-1:0] seq_pc;
  logic [XLEN-1:0] br_pc;
  logic [XLEN-1:0] j_pc;
  logic [XLEN-1:0] jr_pc;
  logic            unused_bits;

  // Level interrupt is only honoured while executing in user mode.
`ifdef FETCH_IRQ_EN
  assign irq_lvl = irq & ~pc[MSB];
  assign unused_bits = ^{branch_target[MSB], branch_target[1:0], jr_target[1:0],
                         id_pc4[MSB], id_pc4[27:0], id_instr[31:26]};
`else
  assign irq_lvl = 1'b0;
  assign unused_bits = ^{irq, branch_target[MSB], branch_target[1:0], jr_target[1:0],
                         id_pc4[MSB], id_pc4[27:0], id_instr[31:26]};
`endif

  // Candidate targets; branch/jump inherit the current mode, jr can only drop to user.
  always_comb begin
    seq_pc = {pc[MSB], pc[MSB-1:0] + (XLEN-1)'(4)};
    br_pc  = {pc[MSB], branch_target[MSB-1:2], 2'b00};
    j_pc   = {pc[MSB], id_pc4[XLEN-2:28], id_instr[25:0], 2'b00};
    jr_pc  = {pc[MSB] & jr_target[MSB], jr_target[MSB-1:2], 2'b00};
  end

  // Redirect priority: irq, illop, jr, jump, taken branch; otherwise sequential.
  always_comb begin
    next_pc  = seq_pc;
    redirect = 1'b0;
    irq_take = irq_lvl | (pcsrc == PCSRC_IRQ);
    if (irq_take) begin
      next_pc  = {XADR_VEC[MSB:2], 2'b00};
      redirect = 1'b1;
    end else if (pcsrc == PCSRC_ILLOP) begin
      next_pc  = {ILLOP_VEC[MSB:2], 2'b00};
      redirect = 1'b1;
    end else if (pcsrc == PCSRC_JR) begin
      next_pc  = jr_pc;
      redirect = 1'b1;
    end else if (pcsrc == PCSRC_J) begin
      next_pc  = j_pc;
      redirect = 1'b1;
    end else if ((pcsrc == PCSRC_BR) && branch_taken) begin
      next_pc  = br_pc;
      redirect = 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC register, next-PC select and IF/ID pipeline register.
// FETCH_IRQ_EN enables the level irq input and the irq_ack pulse.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = XLEN'(RESET_VEC_DEF),
  parameter logic [XLEN-1:0] ILLOP_VEC = XLEN'(ILLOP_VEC_DEF),
  parameter logic [XLEN-1:0] XADR_VEC  = XLEN'(XADR_VEC_DEF)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic [PCSRC_W-1:0] pcsrc,
  input  logic               branch_taken,
  input  logic [XLEN-1:0]    branch_target,
  input  logic [XLEN-1:0]    jr_target,
  input  logic               irq,
  output logic [XLEN-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_ready,
  output logic [INSTR_W-1:0] id_instr,
  output logic [XLEN-1:0]    id_pc4,
  output logic               id_valid,
  output logic               irq_ack
);

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] next_pc;
  logic            redirect;
  logic            irq_take;

  assign imem_addr = pc;

  pc_next_sel #(
    .XLEN      (XLEN),
    .ILLOP_VEC (ILLOP_VEC),
    .XADR_VEC  (XADR_VEC)
  ) u_sel (
    .pc            (pc),
    .pcsrc         (pcsrc),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jr_target     (jr_target),
    .irq           (irq),
    .id_instr      (id_instr),
    .id_pc4        (id_pc4),
    .next_pc       (next_pc),
    .redirect      (redirect),
    .irq_take      (irq_take)
  );

  // PC and IF/ID update: redirect > stall > imem not ready > normal fetch.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc       <= {RESET_VEC[XLEN-1:2], 2'b00};
      id_instr <= NOP_INSTR;
      id_pc4   <= '0;
      id_valid <= 1'b0;
    end else if (redirect) begin
      pc       <= next_pc;
      id_instr <= NOP_INSTR;
      id_pc4   <= '0;
      id_valid <= 1'b0;
    end else if (stall) begin
      pc       <= pc;
    end else if (!imem_ready) begin
      id_instr <= NOP_INSTR;
      id_pc4   <= '0;
      id_valid <= 1'b0;
    end else begin
      pc       <= next_pc;
      id_instr <= imem_rdata;
      id_pc4   <= next_pc;
      id_valid <= 1'b1;
    end
  end

`ifdef FETCH_IRQ_EN
  // One-cycle acknowledge following the interrupt redirect.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_ack <= 1'b0;
    end else begin
      irq_ack <= redirect & irq_take;
    end
  end
`else
  logic unused_irq_take;
  assign unused_irq_take = irq_take;
  assign irq_ack = 1'b0;
`endif

endmodule
